// File: rtl/dram_pkg.sv
// Shared FSM state encoding and reset constants for the DRAM address demultiplexer.
// The CBR state exists only when DRAM_CBR_REFRESH_EN is defined.
package dram_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ROW  = 2'd1,
    ST_COL  = 2'd2
`ifdef DRAM_CBR_REFRESH_EN
    , ST_CBR = 2'd3
`endif
  } state_t;

  localparam state_t STATE_RST  = ST_IDLE;
  localparam logic   STROBE_RST = 1'b1;
  localparam logic   FLAG_RST   = 1'b0;

endpackage

// File: rtl/sync_edge.sv
// Strobe synchronizer with fall/rise detection on the delayed level.
// Edges are masked until the chain has flushed after reset, so a strobe held low through reset is not an edge.
module sync_edge
  import dram_pkg::*;
#(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic level,
  output logic fall,
  output logic rise
);

  localparam int CNT_W = $clog2(STAGES + 2);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;
  logic [CNT_W-1:0]  arm_cnt;
  logic              armed;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= {STAGES{STROBE_RST}};
      prev_q  <= STROBE_RST;
      arm_cnt <= CNT_W'(STAGES + 1);
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d};
      prev_q <= sync_q[STAGES-1];
      if (arm_cnt != '0) arm_cnt <= arm_cnt - CNT_W'(1);
    end
  end

  assign level = sync_q[STAGES-1];
  assign armed = (arm_cnt == '0);
  assign fall  = armed & prev_q & ~level;
  assign rise  = armed & ~prev_q & level;

endmodule

// File: rtl/dram_addr_demux.sv
// Rebuilds a {row, column} address from a RAS/CAS multiplexed DRAM bus and flags refresh cycles.
// Optional CBR refresh detection is enabled by defining DRAM_CBR_REFRESH_EN.
module dram_addr_demux
  import dram_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic [ADDR_W-1:0]   MA,
  input  logic                RAS_N,
  input  logic                CAS_N,
  input  logic                WE_N,
  output logic [2*ADDR_W-1:0] ADDR,
  output logic                WR,
  output logic                VALID,
  output logic                RFSH,
  output logic                ACTIVE
);

  logic ras_level, ras_fall, ras_rise;
  logic cas_level, cas_fall, cas_rise;
  logic we_level, we_fall, we_rise;
  logic unused_edges;

  sync_edge #(.STAGES(SYNC_STAGES)) u_ras (
    .clk(CLK), .rst_n(RST_N), .d(RAS_N), .level(ras_level), .fall(ras_fall), .rise(ras_rise)
  );
  sync_edge #(.STAGES(SYNC_STAGES)) u_cas (
    .clk(CLK), .rst_n(RST_N), .d(CAS_N), .level(cas_level), .fall(cas_fall), .rise(cas_rise)
  );
  sync_edge #(.STAGES(SYNC_STAGES)) u_we (
    .clk(CLK), .rst_n(RST_N), .d(WE_N), .level(we_level), .fall(we_fall), .rise(we_rise)
  );

  assign unused_edges = &{1'b0, cas_rise, we_fall, we_rise};

  // MA follows the same depth as the strobes so the delayed edge sees the matching address.
  logic [ADDR_W-1:0] ma_sr [SYNC_STAGES];
  logic [ADDR_W-1:0] ma_d;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < SYNC_STAGES; i++) ma_sr[i] <= '0;
    end else begin
      ma_sr[0] <= MA;
      for (int i = 1; i < SYNC_STAGES; i++) ma_sr[i] <= ma_sr[i-1];
    end
  end

  assign ma_d = ma_sr[SYNC_STAGES-1];

  state_t            state;
  logic [ADDR_W-1:0] row_q;

  // ADDR is only written on a column capture, so refresh cycles leave it untouched.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state  <= STATE_RST;
      row_q  <= '0;
      ADDR   <= '0;
      WR     <= FLAG_RST;
      VALID  <= FLAG_RST;
      RFSH   <= FLAG_RST;
      ACTIVE <= FLAG_RST;
    end else begin
      VALID <= 1'b0;
      RFSH  <= 1'b0;
      case (state)
        ST_IDLE: begin
`ifdef DRAM_CBR_REFRESH_EN
          if (cas_fall && (ras_level || ras_fall)) begin
            state <= ST_CBR;
            RFSH  <= ras_fall;
          end else if (ras_fall && cas_level) begin
            row_q  <= ma_d;
            state  <= ST_ROW;
            ACTIVE <= 1'b1;
          end
`else
          if (ras_fall && (cas_level || cas_fall)) begin
            row_q  <= ma_d;
            state  <= ST_ROW;
            ACTIVE <= 1'b1;
          end
`endif
        end
        ST_ROW: begin
          if (ras_rise) begin
            RFSH   <= 1'b1;
            state  <= ST_IDLE;
            ACTIVE <= 1'b0;
          end else if (cas_fall) begin
            ADDR  <= {row_q, ma_d};
            WR    <= ~we_level;
            VALID <= 1'b1;
            state <= ST_COL;
          end
        end
        ST_COL: begin
          if (ras_rise) begin
            state  <= ST_IDLE;
            ACTIVE <= 1'b0;
          end else if (cas_fall) begin
            ADDR  <= {row_q, ma_d};
            WR    <= ~we_level;
            VALID <= 1'b1;
          end
        end
`ifdef DRAM_CBR_REFRESH_EN
        ST_CBR: begin
          if (ras_fall) RFSH <= 1'b1;
          else if (ras_level && cas_level) state <= ST_IDLE;
        end
`endif
        default: begin
          state  <= ST_IDLE;
          ACTIVE <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/dram_addr_demux.md
DRAM_ADDR_DEMUX -- requirements
Module: dram_addr_demux

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, giving the multiplexed address width; the reconstructed address is 2*ADDR_W bits.
REQ-002 SHALL have parameter SYNC_STAGES, default 2, giving the number of synchronizer flops on each strobe (legal 2..3).
REQ-003 SHALL have port CLK, input, 1, the only clock; all state is updated on its rising edge.
REQ-004 SHALL have port RST_N, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port MA, input, ADDR_W, the multiplexed row/column address bus.
REQ-006 SHALL have port RAS_N, input, 1, the row strobe, active low and asynchronous to CLK.
REQ-007 SHALL have port CAS_N, input, 1, the column strobe, active low and asynchronous to CLK.
REQ-008 SHALL have port WE_N, input, 1, the write enable, active low.
REQ-009 SHALL have port ADDR, output, 2*ADDR_W, the reconstructed address {row, column}.
REQ-010 SHALL have port WR, output, 1, the registered write flag captured with the column.
REQ-011 SHALL have port VALID, output, 1, a one-CLK pulse on each column capture.
REQ-012 SHALL have port RFSH, output, 1, a one-CLK pulse on each completed refresh cycle.
REQ-013 SHALL have port ACTIVE, output, 1, high while a row is open (state ROW or COL).

Function
REQ-014 SHALL pass RAS_N, CAS_N, WE_N and MA through an identical SYNC_STAGES delay line, then detect edges on the delayed strobes.
REQ-015 SHALL implement FSM states IDLE, ROW, COL and CBR.
REQ-016 IDLE, RAS fall with CAS high SHALL latch the row from delayed MA and go to ROW.
REQ-017 ROW, CAS fall SHALL latch the column and WE, pulse VALID, and go to COL.
REQ-018 ROW, RAS rise with no CAS fall SHALL be a RAS-only refresh: pulse RFSH, then go to IDLE.
REQ-019 COL, CAS rise then fall again while RAS stays low (page mode) SHALL latch the new column and WE and pulse VALID again; the row is unchanged.
REQ-020 COL, RAS rise SHALL go to IDLE; ADDR and WR hold their last values.
REQ-021 Latency from a strobe edge at the pin to VALID or RFSH SHALL be SYNC_STAGES+1 CLK.
REQ-022 RAS fall and CAS fall detected in the same CLK while in IDLE SHALL be treated as a CAS-before-RAS (CBR) refresh (REQ-031/REQ-032).
REQ-023 RAS rise and CAS fall detected in the same CLK in ROW SHALL have RAS priority: no VALID, pulse RFSH, go to IDLE.
REQ-024 A CAS fall in IDLE, or in COL while CAS is still low, SHALL not change state except as given in REQ-031.
REQ-025 VALID and RFSH SHALL never be high in the same cycle.

Reset
REQ-026 RST_N low SHALL force, asynchronously: state IDLE, ADDR=0, WR=0, VALID=0, RFSH=0, ACTIVE=0.
REQ-027 On reset, all synchronizer flops SHALL be set to 1 (strobes inactive).
REQ-028 Reset asserted mid-cycle SHALL abort the access with no VALID or RFSH pulse.
REQ-029 After RST_N rises, a strobe already held low SHALL not be taken as an edge.

Configuration
REQ-030 Macro DRAM_CBR_REFRESH_EN SHALL control CBR refresh detection.
REQ-031 With DRAM_CBR_REFRESH_EN defined: in IDLE, a CAS fall while RAS is high SHALL go to CBR; in CBR, a RAS fall SHALL pulse RFSH; in CBR, RAS and CAS both high SHALL return to IDLE; ADDR is not updated.
REQ-032 With DRAM_CBR_REFRESH_EN undefined: the CBR state SHALL be absent, CAS falls in IDLE are ignored, and the case in REQ-022 is treated as a normal row open.

Structure
REQ-033 The FSM state enum and the reset value constants SHALL be placed in shared package dram_pkg.
REQ-034 The per-strobe synchronizer and edge detector SHALL be sub-module sync_edge (outputs: level, fall, rise), instantiated three times.

Verification
REQ-035 Read: RAS fall with MA=0x12, CAS fall with MA=0x34, WE_N=1 -> one VALID pulse, ADDR=0x1234, WR=0, 3 CLK after the CAS fall.
REQ-036 Page-mode write: row 0xA5, then columns 0x01 and 0x02 with WE_N=0 -> two VALID pulses, ADDR=0xA501 then 0xA502, WR=1.
REQ-037 RAS-only refresh: RAS low for 4 CLK with no CAS -> one RFSH pulse, no VALID pulse, ADDR unchanged.
REQ-038 CBR refresh: CAS low, then RAS low -> RFSH with the macro defined; with the macro undefined -> no RFSH and state stays IDLE.
REQ-039 Reset pulsed while in COL -> all outputs 0 immediately; RAS still low after reset -> no VALID pulse.
REQ-040 Same-cycle RAS rise and CAS fall in ROW -> RFSH pulse, no VALID pulse.
